// File: rtl/imm_ext_pipe_pkg.sv
// Shared immediate-extension mode encodings, also consumed by the control unit.
// Mode values are fixed ISA-side; widen EXT_MODE_W only together with the decoder.
package imm_ext_pipe_pkg;

    localparam int EXT_MODE_W = 3;

    typedef logic [EXT_MODE_W-1:0] ext_mode_t;

    localparam ext_mode_t EXT_SEXT   = 3'd0;
    localparam ext_mode_t EXT_ZEXT   = 3'd1;
    localparam ext_mode_t EXT_LUI    = 3'd2;
    localparam ext_mode_t EXT_BRANCH = 3'd3;
    localparam ext_mode_t EXT_JUMP   = 3'd4;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: mode mux over sext/zext/lui/branch/jump.
// Latency: 0 cycles (pure logic).
// Backpressure: none; the caller registers the result.
module imm_ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W   = 26,
    parameter int IMM_W  = 16,
    parameter int OUT_W  = 32,
    parameter int LUI_SH = 16
) (
    input  logic [IN_W-1:0]       ImmIn,
    input  logic [EXT_MODE_W-1:0] ExtMode,
    output logic [OUT_W-1:0]      ImmOut,
    output logic                  ErrOut
);

    logic [IMM_W-1:0] imm_field;
    logic [OUT_W-1:0] sext_dat;
    logic [OUT_W-1:0] zext_dat;
    logic [OUT_W-1:0] lui_dat;
    logic [OUT_W-1:0] branch_dat;
    logic [OUT_W-1:0] jump_dat;

    assign imm_field  = ImmIn[IMM_W-1:0];
    assign sext_dat   = {{(OUT_W-IMM_W){imm_field[IMM_W-1]}}, imm_field};
    assign zext_dat   = {{(OUT_W-IMM_W){1'b0}}, imm_field};
    assign lui_dat    = zext_dat << LUI_SH;
    assign branch_dat = sext_dat << 2;
    // Jump target is word-aligned; the PC upper bits are merged downstream.
    assign jump_dat   = {{(OUT_W-IN_W){1'b0}}, ImmIn} << 2;

    always_comb begin
        ImmOut = '0;
        ErrOut = 1'b0;
        case (ExtMode)
            EXT_SEXT:   ImmOut = sext_dat;
            EXT_ZEXT:   ImmOut = zext_dat;
            EXT_LUI:    ImmOut = lui_dat;
            EXT_BRANCH: ImmOut = branch_dat;
            EXT_JUMP:   ImmOut = jump_dat;
            default:    ErrOut = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator between ID decode and the ID/EX register.
// Latency: 1 cycle unstalled, 1 beat/cycle throughput.
// Backpressure: one-entry skid; InReady depends only on skid state, never on OutReady.
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W   = 26,
    parameter int IMM_W  = 16,
    parameter int OUT_W  = 32,
    parameter int LUI_SH = 16,
    parameter int TAG_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [IN_W-1:0]       ImmIn,
    input  logic [EXT_MODE_W-1:0] ExtMode,
    input  logic [TAG_W-1:0]      TagIn,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [OUT_W-1:0]      ImmOut,
    output logic [TAG_W-1:0]      TagOut,
    output logic                  ErrOut
);

    typedef struct packed {
        logic [OUT_W-1:0] imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } beat_t;

    beat_t in_dat;
    beat_t out_dat;
    beat_t skid_dat;
    logic  out_vld;
    logic  skid_vld;
    logic  in_xfer;
    logic  out_free;

    // Extension happens before the registers so both entries hold final operands.
    imm_ext_core #(
        .IN_W   (IN_W),
        .IMM_W  (IMM_W),
        .OUT_W  (OUT_W),
        .LUI_SH (LUI_SH)
    ) u_core (
        .ImmIn   (ImmIn),
        .ExtMode (ExtMode),
        .ImmOut  (in_dat.imm),
        .ErrOut  (in_dat.err)
    );

    assign in_dat.tag = TagIn;

    assign InReady  = rst_n && !skid_vld;
    assign in_xfer  = InValid && InReady;
    assign out_free = !out_vld || OutReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (out_free) begin
            if (skid_vld) begin
                // Skid full implies InReady was low, so no new beat competes here.
                out_dat  <= skid_dat;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (in_xfer) begin
                out_dat <= in_dat;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_dat <= in_dat;
            skid_vld <= 1'b1;
        end
    end

    assign OutValid = out_vld;
    assign ImmOut   = out_dat.imm;
    assign TagOut   = out_dat.tag;
    assign ErrOut   = out_dat.err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Randomised and directed checks of imm_ext_pipe against an arithmetic reference model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid;
    logic        InReady;
    logic [25:0] ImmIn;
    logic [2:0]  ExtMode;
    logic [4:0]  TagIn;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ImmOut;
    logic [4:0]  TagOut;
    logic        ErrOut;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .ImmIn    (ImmIn),
        .ExtMode  (ExtMode),
        .TagIn    (TagIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ImmOut   (ImmOut),
        .TagOut   (TagOut),
        .ErrOut   (ErrOut)
    );

    // Reference: {err, imm} computed with signed integer arithmetic.
    function automatic logic [32:0] ref_ext(input int mode, input logic [25:0] raw);
        longint e, s, v;
        logic [63:0] w;
        e = longint'(raw) % 65536;
        s = (e >= 32768) ? e - 65536 : e;
        case (mode)
            0: v = s;
            1: v = e;
            2: v = e * 65536;
            3: v = s * 4;
            4: v = longint'(raw) * 4;
            default: return {1'b1, 32'h0};
        endcase
        w = v;
        return {1'b0, w[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int mode, input logic [25:0] raw, input logic [4:0] tag);
        InValid = 1'b1;
        ExtMode = mode[2:0];
        ImmIn   = raw;
        TagIn   = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        ImmIn = '0; ExtMode = '0; TagIn = '0;
        #3;
        vectors++;
        if (OutValid !== 1'b0 || ImmOut !== 32'h0 || TagOut !== 5'h0 || ErrOut !== 1'b0 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: OutValid=%b ImmOut=%h TagOut=%h ErrOut=%b InReady=%b, want 0 0 0 0 0",
                     OutValid, ImmOut, TagOut, ErrOut, InReady);
        end
        step(); step();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: InReady=%b want 1", InReady);
        end
        // Fill output and skid, then reset mid-transfer.
        drive(0, 26'h11, 5'd1); step();
        drive(0, 26'h22, 5'd2); step();
        InValid = 1'b0;
        vectors++;
        if (InReady !== 1'b0 || OutValid !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill: InReady=%b OutValid=%b want 0 1", InReady, OutValid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (OutValid !== 1'b0 || ImmOut !== 32'h0 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_midflight: OutValid=%b ImmOut=%h InReady=%b want 0 0 0", OutValid, ImmOut, InReady);
        end
        step();
        #2 rst_n = 1'b1;
        OutReady = 1'b1;
        step();
        vectors++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_stale_a: InReady=%b OutValid=%b want 1 0", InReady, OutValid);
        end
        step();
        vectors++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_stale_b: OutValid=%b want 0", OutValid);
        end
    endtask

    task automatic run_table(input string name, input int modes[4], input logic [25:0] raws[4],
                             input logic [31:0] want[4]);
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(modes[i], raws[i], 5'(i + 3));
            step();
            vectors++;
            if (OutValid !== 1'b1 || ImmOut !== want[i] || ErrOut !== 1'b0 || TagOut !== 5'(i + 3)) begin
                errors++;
                $display("FAIL %s[%0d]: OutValid=%b ImmOut=%h ErrOut=%b TagOut=%0d want 1 %h 0 %0d",
                         name, i, OutValid, ImmOut, ErrOut, TagOut, want[i], i + 3);
            end
        end
        InValid = 1'b0;
        step();
        vectors++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: OutValid=%b want 0", name, OutValid);
        end
    endtask

    task automatic test_modes();
        run_table("modes", '{0, 1, 2, 0}, '{26'h8000, 26'h8000, 26'h1234, 26'h7FFF},
                  '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'h00007FFF});
    endtask

    task automatic test_branch_jump();
        run_table("brjmp", '{3, 3, 4, 4}, '{26'hFFFF, 26'h0004, 26'h3FFFFFF, 26'h0000001},
                  '{32'hFFFFFFFC, 32'h00000010, 32'h0FFFFFFC, 32'h00000004});
    endtask

    task automatic check_out(input string name, input logic vld, input logic [4:0] tag, input logic [31:0] imm);
        vectors++;
        if (OutValid !== vld || (vld && (TagOut !== tag || ImmOut !== imm))) begin
            errors++;
            $display("FAIL %s: OutValid=%b TagOut=%0d ImmOut=%h want %b %0d %h",
                     name, OutValid, TagOut, ImmOut, vld, tag, imm);
        end
    endtask

    task automatic test_back_to_back();
        OutReady = 1'b0;
        drive(0, 26'h1, 5'd1); step();
        drive(0, 26'h2, 5'd2); step();
        drive(0, 26'h3, 5'd3);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (InReady !== 1'b0) begin
                errors++;
                $display("FAIL bp_inready_low[%0d]: InReady=%b want 0", i, InReady);
            end
            check_out("bp_hold", 1'b1, 5'd1, 32'h1);
            step();
        end
        OutReady = 1'b1;
        check_out("bp_first", 1'b1, 5'd1, 32'h1);
        step();
        check_out("bp_second", 1'b1, 5'd2, 32'h2);
        vectors++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL bp_inready_back: InReady=%b want 1", InReady);
        end
        step();
        InValid = 1'b0;
        check_out("bp_third", 1'b1, 5'd3, 32'h3);
        step();
        check_out("bp_empty", 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_illegal();
        OutReady = 1'b1;
        drive(7, 26'h1234, 5'd9); step();
        vectors++;
        if (OutValid !== 1'b1 || ImmOut !== 32'h0 || ErrOut !== 1'b1 || TagOut !== 5'd9) begin
            errors++;
            $display("FAIL illegal: OutValid=%b ImmOut=%h ErrOut=%b TagOut=%0d want 1 0 1 9",
                     OutValid, ImmOut, ErrOut, TagOut);
        end
        drive(0, 26'h0005, 5'd10); step();
        InValid = 1'b0;
        vectors++;
        if (ErrOut !== 1'b0 || ImmOut !== 32'h5 || TagOut !== 5'd10) begin
            errors++;
            $display("FAIL illegal_clear: ErrOut=%b ImmOut=%h TagOut=%0d want 0 5 10", ErrOut, ImmOut, TagOut);
        end
        step();
    endtask

    task automatic test_stream();
        logic [37:0] q[$];
        logic [37:0] exp_b;
        logic [32:0] r;
        int sent = 0;
        int budget = 0;
        logic held = 1'b0;
        logic [37:0] held_b = '0;
        InValid = 1'b0;
        while ((sent < 100 || q.size() > 0) && budget < 2000) begin
            budget++;
            if (sent < 100 && $urandom_range(9) < 7)
                drive(int'($urandom_range(7)), 26'($urandom), 5'($urandom));
            else
                InValid = 1'b0;
            OutReady = $urandom_range(1);
            #1;
            vectors++;
            if (OutValid !== (q.size() > 0) || InReady !== (q.size() < 2)) begin
                errors++;
                $display("FAIL stream_occupancy: OutValid=%b InReady=%b held=%0d", OutValid, InReady, q.size());
            end
            if (held) begin
                vectors++;
                if ({ErrOut, TagOut, ImmOut} !== held_b) begin
                    errors++;
                    $display("FAIL stream_stable: got %h want %h", {ErrOut, TagOut, ImmOut}, held_b);
                end
            end
            held = 1'b0;
            if (OutValid && q.size() > 0) begin
                exp_b = q[0];
                vectors++;
                if ({ErrOut, TagOut, ImmOut} !== exp_b) begin
                    errors++;
                    $display("FAIL stream_data: err/tag/imm got %h want %h", {ErrOut, TagOut, ImmOut}, exp_b);
                end
                if (OutReady) void'(q.pop_front());
                else begin
                    held = 1'b1;
                    held_b = {ErrOut, TagOut, ImmOut};
                end
            end
            if (InValid && InReady) begin
                r = ref_ext(int'(ExtMode), ImmIn);
                q.push_back({r[32], TagIn, r[31:0]});
                sent++;
            end
            vectors++;
            if (q.size() > 2) begin
                errors++;
                $display("FAIL stream_outstanding: %0d beats in flight, limit 2", q.size());
            end
            @(posedge clk);
            #1;
        end
        InValid = 1'b0;
        vectors++;
        if (sent != 100 || q.size() != 0) begin
            errors++;
            $display("FAIL stream_budget: sent=%0d left=%0d want 100 0", sent, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_branch_jump();
        test_back_to_back();
        test_illegal();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
